// File: rtl/ula_result_fifo.sv
// First-word-fall-through result buffer between the ULA and its consumer.
// Captures every ULA result pulse, drops results on overflow and flags them with a sticky bit.
module ula_result_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  ready_i,
  input  logic                  clr_ovf_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  overflow_o
);

  localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE    = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic ovf_event;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_COUNT);

  // A pop frees a slot on the same edge, so a full FIFO can still accept a result.
  assign pop       = !empty && ready_i;
  assign push      = valid_i && (!full || pop);
  assign ovf_event = valid_i && full && !pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end

    // A new overflow on the clearing edge must not be lost.
    if (ovf_event) begin
      overflow_d = 1'b1;
    end else if (clr_ovf_i) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign valid_o    = !empty;
  assign empty_o    = empty;
  assign full_o     = full;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign data_o     = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_ula_result_fifo.sv
// Scoreboard bench for ula_result_fifo: stimulus queues expected results,
// a negedge monitor checks each word as the consumer takes it.
module tb_ula_result_fifo;

  localparam int DW = 16;
  localparam int AW = 2;

  logic          clk;
  logic          rst_n;
  logic          valid_i;
  logic [DW-1:0] data_i;
  logic          ready_i;
  logic          clr_ovf_i;
  logic          valid_o;
  logic [DW-1:0] data_o;
  logic          full_o;
  logic          empty_o;
  logic [AW:0]   count_o;
  logic          overflow_o;

  int assertCount = 0;
  int failCount   = 0;
  logic [DW-1:0] expQ [$];

  ula_result_fifo #(.DATA_WIDTH(DW), .DEPTH(4), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_i    (valid_i),
    .data_i     (data_i),
    .ready_i    (ready_i),
    .clr_ovf_i  (clr_ovf_i),
    .valid_o    (valid_o),
    .data_o     (data_o),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .count_o    (count_o),
    .overflow_o (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so a stuck run still ends with a visible failure.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Drive one ULA result for a single cycle; accepted results go to the scoreboard.
  task automatic applyStimulus(input logic [DW-1:0] value, input bit accepted);
    valid_i = 1'b1;
    data_i  = value;
    if (accepted) expQ.push_back(value);
    cycle();
    valid_i = 1'b0;
    data_i  = '0;
  endtask

  // Monitor: a handshake seen at negedge completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && valid_o && ready_i) begin
      if (expQ.size() == 0) begin
        checkOutput("sb_underflow", {16'h0, data_o}, 32'hFFFF_FFFF);
      end else begin
        checkOutput("sb_data", {16'h0, data_o}, {16'h0, expQ.pop_front()});
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    valid_i   = 1'b0;
    data_i    = '0;
    ready_i   = 1'b0;
    clr_ovf_i = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;

    // Reset then idle
    cycle();
    checkOutput("rst_valid", 32'(valid_o), 32'd0);
    checkOutput("rst_data", 32'(data_o), 32'd0);
    checkOutput("rst_empty", 32'(empty_o), 32'd1);
    checkOutput("rst_full", 32'(full_o), 32'd0);
    checkOutput("rst_count", 32'(count_o), 32'd0);
    checkOutput("rst_ovf", 32'(overflow_o), 32'd0);

    // Single pass with one-cycle fall-through
    ready_i = 1'b1;
    applyStimulus(16'h0005, 1'b1);
    checkOutput("pass_valid", 32'(valid_o), 32'd1);
    checkOutput("pass_data", 32'(data_o), 32'h5);
    cycle();
    checkOutput("pass_valid_after", 32'(valid_o), 32'd0);
    checkOutput("pass_count_after", 32'(count_o), 32'd0);

    // Fill exactly to DEPTH, then drain
    ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) applyStimulus(DW'(i), 1'b1);
    checkOutput("fill_full", 32'(full_o), 32'd1);
    checkOutput("fill_count", 32'(count_o), 32'd4);
    checkOutput("fill_ovf", 32'(overflow_o), 32'd0);
    checkOutput("fill_head", 32'(data_o), 32'h1);
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    ready_i = 1'b0;
    checkOutput("drain_empty", 32'(empty_o), 32'd1);
    checkOutput("drain_count", 32'(count_o), 32'd0);

    // Overflow drops the result and sets the sticky flag
    for (int i = 1; i <= 4; i++) applyStimulus(DW'(i), 1'b1);
    applyStimulus(16'h00FF, 1'b0);
    checkOutput("ovf_flag", 32'(overflow_o), 32'd1);
    checkOutput("ovf_count", 32'(count_o), 32'd4);
    checkOutput("ovf_head", 32'(data_o), 32'h1);
    cycle();
    checkOutput("hold_head", 32'(data_o), 32'h1);
    clr_ovf_i = 1'b1;
    cycle();
    clr_ovf_i = 1'b0;
    checkOutput("ovf_cleared", 32'(overflow_o), 32'd0);
    clr_ovf_i = 1'b1;
    applyStimulus(16'h00EE, 1'b0);
    clr_ovf_i = 1'b0;
    checkOutput("ovf_set_wins", 32'(overflow_o), 32'd1);
    clr_ovf_i = 1'b1;
    cycle();
    clr_ovf_i = 1'b0;
    checkOutput("ovf_cleared2", 32'(overflow_o), 32'd0);

    // Full with simultaneous push and pop
    ready_i = 1'b1;
    applyStimulus(16'h0009, 1'b1);
    ready_i = 1'b0;
    checkOutput("pp_count", 32'(count_o), 32'd4);
    checkOutput("pp_full", 32'(full_o), 32'd1);
    checkOutput("pp_ovf", 32'(overflow_o), 32'd0);
    checkOutput("pp_head", 32'(data_o), 32'h2);
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    ready_i = 1'b0;
    checkOutput("pp_drain_empty", 32'(empty_o), 32'd1);

    // Asynchronous reset between clock edges
    applyStimulus(16'h0011, 1'b1);
    applyStimulus(16'h0022, 1'b1);
    applyStimulus(16'h0033, 1'b1);
    checkOutput("ar_count_before", 32'(count_o), 32'd3);
    #2;
    rst_n = 1'b0;
    expQ.delete();
    #1;
    checkOutput("ar_count", 32'(count_o), 32'd0);
    checkOutput("ar_valid", 32'(valid_o), 32'd0);
    checkOutput("ar_data", 32'(data_o), 32'd0);
    checkOutput("ar_empty", 32'(empty_o), 32'd1);
    cycle();
    rst_n = 1'b1;
    cycle();
    ready_i = 1'b1;
    applyStimulus(16'hABCD, 1'b1);
    checkOutput("ar_new_data", 32'(data_o), 32'hABCD);
    checkOutput("ar_new_count", 32'(count_o), 32'd1);
    cycle();
    checkOutput("ar_final_empty", 32'(empty_o), 32'd1);
    cycle();
    checkOutput("sb_leftover", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
